// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART TX scheduler: FSM encoding, default timing
// parameters and a counter-width helper.
package uart_tx_scheduler_pkg;

    localparam int BYTE_W            = 8;
    localparam int DEF_GAP_CYCLES    = 16;
    localparam int DEF_STALL_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester above last_gnt, wrapping,
// returned both one-hot and as an index.
module uart_tx_scheduler_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int GNT_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GNT_W-1:0] last_gnt,
    output logic [N_REQ-1:0] gnt_oh,
    output logic [GNT_W-1:0] gnt_idx
);

    logic             found;
    logic [GNT_W-1:0] idx;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = GNT_W'((int'(last_gnt) + i) % N_REQ);
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among N_REQ byte-stream requesters, one whole
// frame at a time, with an idle gap between frames and a stall abort.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter int STALL_TIMEOUT = DEF_STALL_TIMEOUT,
    parameter int GNT_W         = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ack,
    output logic [BYTE_W-1:0]       uart_tx_data,
    output logic                    uart_tx_data_ready,
    input  logic                    uart_tx_over,
    output logic                    busy,
    output logic [GNT_W-1:0]        grant_id,
    output logic                    frame_done,
    output logic                    frame_abort,
    output state_e                  state_dbg
);

    // Handshake: a requester holds req_valid/req_data/req_last steady until it
    // sees its 1-cycle req_ack; each byte goes out as a 1-cycle
    // uart_tx_data_ready and is finished when the 1-cycle uart_tx_over returns.

    localparam int STALL_W = cnt_width(STALL_TIMEOUT);
    localparam int GAP_W   = cnt_width(GAP_CYCLES);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_TIMEOUT);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam state_e END_STATE = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

    state_e             state;
    logic [GNT_W-1:0]   last_gnt;
    logic [N_REQ-1:0]   gnt_oh_q;
    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_inc;
    logic [GAP_W-1:0]   gap_cnt;
    logic               last_flag;
    logic [N_REQ-1:0]   arb_oh;
    logic [GNT_W-1:0]   arb_idx;

    uart_tx_scheduler_rr_arbiter #(
        .N_REQ (N_REQ),
        .GNT_W (GNT_W)
    ) u_arb (
        .req      (req_valid),
        .last_gnt (last_gnt),
        .gnt_oh   (arb_oh),
        .gnt_idx  (arb_idx)
    );

    assign stall_inc = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 1'b1;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            last_gnt           <= GNT_W'(N_REQ - 1);
            gnt_oh_q           <= '0;
            grant_id           <= '0;
            stall_cnt          <= '0;
            gap_cnt            <= '0;
            last_flag          <= 1'b0;
            uart_tx_data       <= '0;
            uart_tx_data_ready <= 1'b0;
            req_ack            <= '0;
            frame_done         <= 1'b0;
            frame_abort        <= 1'b0;
        end else begin
            uart_tx_data_ready <= 1'b0;
            req_ack            <= '0;
            frame_done         <= 1'b0;
            frame_abort        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        grant_id  <= arb_idx;
                        gnt_oh_q  <= arb_oh;
                        last_gnt  <= arb_idx;
                        stall_cnt <= '0;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (|(req_valid & gnt_oh_q)) begin
                        uart_tx_data       <= req_data[grant_id*BYTE_W +: BYTE_W];
                        uart_tx_data_ready <= 1'b1;
                        req_ack            <= gnt_oh_q;
                        last_flag          <= |(req_last & gnt_oh_q);
                        state              <= ST_WAIT;
                    end else begin
                        stall_cnt <= stall_inc;
                        if (stall_inc == STALL_MAX) begin
                            frame_abort <= 1'b1;
                            gap_cnt     <= '0;
                            state       <= END_STATE;
                        end
                    end
                end
                ST_WAIT: begin
                    // Requester inputs are deliberately ignored while a byte is on the line.
                    if (uart_tx_over) begin
                        if (last_flag) begin
                            frame_done <= 1'b1;
                            gap_cnt    <= '0;
                            state      <= END_STATE;
                        end else begin
                            stall_cnt <= '0;
                            state     <= ST_LOAD;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: requester queues, an 80-cycle transceiver model
// and a byte scoreboard, plus a GAP_CYCLES=0 instance for back-to-back frames.
module tb_uart_tx_scheduler;
    import uart_tx_scheduler_pkg::*;

    localparam int N      = 4;
    localparam int BYTE_T = 80;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]   req_valid, req_last, req_ack;
    logic [8*N-1:0] req_data;
    logic [7:0]     uart_tx_data;
    logic           uart_tx_data_ready, uart_tx_over, busy, frame_done, frame_abort;
    logic [1:0]     grant_id;
    state_e         state_dbg;

    logic [N-1:0]   r2_valid, r2_last, r2_ack;
    logic [8*N-1:0] r2_data;
    logic [7:0]     d2_data;
    logic           d2_ready, r2_over, d2_busy, d2_done, d2_abort;
    logic [1:0]     d2_grant;
    state_e         d2_state;

    uart_tx_scheduler #(.N_REQ(N), .GAP_CYCLES(16), .STALL_TIMEOUT(1023)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ack(req_ack), .uart_tx_data(uart_tx_data),
        .uart_tx_data_ready(uart_tx_data_ready), .uart_tx_over(uart_tx_over),
        .busy(busy), .grant_id(grant_id), .frame_done(frame_done),
        .frame_abort(frame_abort), .state_dbg(state_dbg)
    );

    uart_tx_scheduler #(.N_REQ(N), .GAP_CYCLES(0), .STALL_TIMEOUT(7)) dut_nogap (
        .clk(clk), .rst(rst), .req_valid(r2_valid), .req_data(r2_data),
        .req_last(r2_last), .req_ack(r2_ack), .uart_tx_data(d2_data),
        .uart_tx_data_ready(d2_ready), .uart_tx_over(r2_over),
        .busy(d2_busy), .grant_id(d2_grant), .frame_done(d2_done),
        .frame_abort(d2_abort), .state_dbg(d2_state)
    );

    // Scoreboard: {last, grant, byte} expected on each data_ready, in order.
    logic [10:0] exp_q[$];
    logic [8:0]  rq[N][$];
    logic [N-1:0] noise = '0;
    int n_chk = 0, n_pass = 0;
    int n_ready = 0, n_done = 0, n_abort = 0, n_ack1 = 0, n_over = 0;
    int last_ready_cyc = 0, last_over_cyc = 0, bt = 0;
    bit prev_last = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit rq_empty();
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // which: 0 frame_done, 1 frame_abort, 2 busy, 3 all drained and idle,
    // 4 second-instance data_ready, 5 n_ready >= target, 6 n_over >= target
    task automatic wait_for(input int which, input int budget, input string name, input int target = 0);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < budget) begin
            step();
            n++;
            case (which)
                0: hit = frame_done;
                1: hit = frame_abort;
                2: hit = busy;
                3: hit = (exp_q.size() == 0) && !busy && rq_empty();
                4: hit = d2_ready;
                5: hit = (n_ready >= target);
                6: hit = (n_over >= target);
                default: hit = 1'b1;
            endcase
        end
        if (!hit) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Requesters: hold the queue head until acked; noise[i] toggles valid with nothing behind it.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (req_ack[i]) begin
                    check($sformatf("ack_has_byte_%0d", i), 32'(rq[i].size() > 0), 32'd1);
                    if (rq[i].size() > 0) void'(rq[i].pop_front());
                end
            end
            for (int i = 0; i < N; i++) begin
                if (rq[i].size() > 0) begin
                    req_valid[i]      = 1'b1;
                    req_data[8*i +: 8] = rq[i][0][7:0];
                    req_last[i]       = rq[i][0][8];
                end else begin
                    req_valid[i]      = noise[i] & 1'($urandom_range(0, 1));
                    req_data[8*i +: 8] = 8'($urandom_range(0, 255));
                    req_last[i]       = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Transceiver model: uart_tx_over pulses BYTE_T cycles after each data_ready.
    initial begin
        uart_tx_over = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            uart_tx_over = 1'b0;
            if (bt > 0) begin
                bt--;
                if (bt == 0) begin
                    uart_tx_over  = 1'b1;
                    n_over++;
                    last_over_cyc = cyc;
                end
            end
            if (uart_tx_data_ready) bt = BYTE_T;
        end
    end

    // Output monitor and scoreboard compare.
    initial begin
        logic [10:0] item;
        forever begin
            @(posedge clk);
            #1;
            if (uart_tx_data_ready) begin
                n_ready++;
                last_ready_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_byte", {24'd0, uart_tx_data}, 32'hFFFF_FFFF);
                end else begin
                    item = exp_q.pop_front();
                    check("sb_data", {24'd0, uart_tx_data}, {24'd0, item[7:0]});
                    check("sb_grant", {30'd0, grant_id}, {30'd0, item[9:8]});
                    if (!prev_last) check("over_to_ready", 32'(cyc - last_over_cyc), 32'd2);
                    prev_last = item[10];
                end
            end
            if (req_ack[1]) n_ack1++;
            if (frame_done) n_done++;
            if (frame_abort) n_abort++;
        end
    end

    typedef struct packed {
        logic [3:0] mask;
        logic [7:0] ord;
        logic [2:0] n;
    } vec_t;
    vec_t vecs[5];

    function automatic logic [7:0] vbyte(input int v, input int i);
        return 8'(8'h40 + 16 * v + i);
    endfunction

    initial begin
        int nr, nd, na, no, start, done_cyc, g, k0, t0;
        logic [7:0] o;
        logic [1:0] gi;

        // Service order assumes last_gnt carried over from the previous vector (0 after test 1).
        vecs[0] = '{mask: 4'b1111, ord: {2'd0, 2'd3, 2'd2, 2'd1}, n: 3'd4};
        vecs[1] = '{mask: 4'b0101, ord: {4'd0, 2'd0, 2'd2},       n: 3'd2};
        vecs[2] = '{mask: 4'b1001, ord: {4'd0, 2'd0, 2'd3},       n: 3'd2};
        vecs[3] = '{mask: 4'b0010, ord: {6'd0, 2'd1},             n: 3'd1};
        vecs[4] = '{mask: 4'b1100, ord: {4'd0, 2'd3, 2'd2},       n: 3'd2};

        r2_valid = '0;
        r2_data  = '0;
        r2_last  = '0;
        r2_over  = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check("rst_ack", {28'd0, req_ack}, 32'd0);
        check("rst_data", {24'd0, uart_tx_data}, 32'd0);
        check("rst_ready", {31'd0, uart_tx_data_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_grant", {30'd0, grant_id}, 32'd0);
        check("rst_done_abort", {30'd0, frame_done, frame_abort}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
        rst = 1'b0;
        step();

        // Test 1: three-byte frame from requester 0, then the gap
        nr = n_ready; nd = n_done; start = cyc;
        rq[0].push_back({1'b0, 8'h11}); rq[0].push_back({1'b0, 8'h22}); rq[0].push_back({1'b1, 8'h33});
        exp_q.push_back({1'b0, 2'd0, 8'h11}); exp_q.push_back({1'b0, 2'd0, 8'h22});
        exp_q.push_back({1'b1, 2'd0, 8'h33});
        wait_for(5, 200, "t1_first", nr + 1);
        check("t1_idle_to_ready", 32'(last_ready_cyc - start), 32'd2);
        wait_for(0, 600, "t1_done");
        check("t1_byte_count", 32'(n_ready - nr), 32'd3);
        g = 0;
        while (busy && g < 100) begin g++; step(); end
        check("t1_gap_cycles", 32'(g), 32'd16);
        check("t1_done_once", 32'(n_done - nd), 32'd1);
        check("t1_state_idle", {30'd0, state_dbg}, {30'd0, ST_IDLE});

        // Test 2: table of simultaneous one-byte frames and their rotation order
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < N; i++)
                if (vecs[v].mask[i]) rq[i].push_back({1'b1, vbyte(v, i)});
            o = vecs[v].ord;
            for (int k = 0; k < int'(vecs[v].n); k++) begin
                gi = o[2*k +: 2];
                exp_q.push_back({1'b1, gi, vbyte(v, int'(gi))});
            end
            wait_for(3, 1500, $sformatf("t2_vec%0d", v));
        end

        // Test 3: requester 1 chatters during requester 2's frame, then waits out the gap
        rq[2].push_back({1'b0, 8'h21}); rq[2].push_back({1'b0, 8'h22}); rq[2].push_back({1'b1, 8'h23});
        exp_q.push_back({1'b0, 2'd2, 8'h21}); exp_q.push_back({1'b0, 2'd2, 8'h22});
        exp_q.push_back({1'b1, 2'd2, 8'h23});
        wait_for(2, 20, "t3_busy");
        noise[1] = 1'b1;
        na = n_ack1;
        wait_for(0, 800, "t3_done");
        done_cyc = cyc;
        check("t3_grant_held", {30'd0, grant_id}, 32'd2);
        noise[1] = 1'b0;
        rq[1].push_back({1'b1, 8'h5A});
        exp_q.push_back({1'b1, 2'd1, 8'h5A});
        check("t3_no_ack_req1", 32'(n_ack1 - na), 32'd0);
        wait_for(3, 600, "t3_drain");
        check("t3_valid_waits_gap", 32'(last_ready_cyc - done_cyc), 32'd18);

        // Test 4: requester 3 stalls after its first byte
        nd = n_done; na = n_abort;
        rq[3].push_back({1'b0, 8'h3C});
        exp_q.push_back({1'b0, 2'd3, 8'h3C});
        wait_for(1, 1500, "t4_abort");
        check("t4_stall_len", 32'(cyc - last_over_cyc), 32'd1024);
        prev_last = 1'b1;
        nr = n_ready;
        repeat (40) step();
        check("t4_no_more_bytes", 32'(n_ready - nr), 32'd0);
        check("t4_no_done", 32'(n_done - nd), 32'd0);
        check("t4_abort_once", 32'(n_abort - na), 32'd1);
        check("t4_idle", {31'd0, busy}, 32'd0);
        rq[0].push_back({1'b1, 8'h01}); rq[0].push_back({1'b1, 8'h02});
        rq[1].push_back({1'b1, 8'h12}); rq[2].push_back({1'b1, 8'h23}); rq[3].push_back({1'b1, 8'h34});
        exp_q.push_back({1'b1, 2'd0, 8'h01}); exp_q.push_back({1'b1, 2'd1, 8'h12});
        exp_q.push_back({1'b1, 2'd2, 8'h23}); exp_q.push_back({1'b1, 2'd3, 8'h34});
        exp_q.push_back({1'b1, 2'd0, 8'h02});
        wait_for(3, 2000, "t4_rotation");

        // Test 5: reset while byte 2 of requester 1's frame is on the line
        nr = n_ready;
        rq[1].push_back({1'b0, 8'hA1}); rq[1].push_back({1'b0, 8'hA2}); rq[1].push_back({1'b1, 8'hA3});
        exp_q.push_back({1'b0, 2'd1, 8'hA1}); exp_q.push_back({1'b0, 2'd1, 8'hA2});
        wait_for(5, 400, "t5_byte2", nr + 2);
        repeat (10) step();
        rst = 1'b1;
        rq[1].delete();
        prev_last = 1'b1;
        step();
        check("t5_rst_ack", {28'd0, req_ack}, 32'd0);
        check("t5_rst_data", {24'd0, uart_tx_data}, 32'd0);
        check("t5_rst_ready", {31'd0, uart_tx_data_ready}, 32'd0);
        check("t5_rst_grant", {30'd0, grant_id}, 32'd0);
        check("t5_rst_busy", {31'd0, busy}, 32'd0);
        check("t5_rst_pulses", {30'd0, frame_done, frame_abort}, 32'd0);
        rst = 1'b0;
        no = n_over; nr = n_ready;
        wait_for(6, 200, "t5_stray_over", no + 1);
        repeat (3) step();
        check("t5_stray_ignored", {31'd0, busy}, 32'd0);
        check("t5_no_bytes", 32'(n_ready - nr), 32'd0);
        rq[0].push_back({1'b1, 8'hB0}); rq[3].push_back({1'b1, 8'hB3});
        exp_q.push_back({1'b1, 2'd0, 8'hB0}); exp_q.push_back({1'b1, 2'd3, 8'hB3});
        wait_for(3, 800, "t5_after_reset");

        // Test 6: no-gap instance, back-to-back frames from requesters 0 and 1
        r2_data  = {16'd0, 8'hC1, 8'hC0};
        r2_last  = 4'b1111;
        r2_valid = 4'b0011;
        k0 = cyc;
        wait_for(4, 10, "t6_first");
        check("t6_first_latency", 32'(cyc - k0), 32'd2);
        check("t6_first_data", {24'd0, d2_data}, 32'hC0);
        check("t6_first_ack", {28'd0, r2_ack}, 32'b0001);
        r2_valid[0] = 1'b0;
        repeat (5) step();
        r2_over = 1'b1;
        t0 = cyc;
        step();
        r2_over = 1'b0;
        check("t6_done", {31'd0, d2_done}, 32'd1);
        check("t6_idle_between", {31'd0, d2_busy}, 32'd0);
        step();
        check("t6_regrant", {30'd0, d2_grant}, 32'd1);
        step();
        check("t6_second_latency", 32'(cyc - t0), 32'd3);
        check("t6_second_ready", {31'd0, d2_ready}, 32'd1);
        check("t6_second_data", {24'd0, d2_data}, 32'hC1);
        r2_valid = '0;
        step();
        r2_over = 1'b1;
        step();
        r2_over = 1'b0;
        check("t6_done2", {31'd0, d2_done}, 32'd1);
        step();
        check("t6_final_idle", {31'd0, d2_busy}, 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
